sr_ff_arbiter: RTL and testbench

Shares one SR flip-flop between two requesters. Each requester issues set or reset commands through a req/ack handshake. The block arbitrates round-robin and drives the flip-flop's `s`/`r` inputs for a programmable pulse width, with `s` and `r` never asserted together. After each pulse it reads back `q` and flags any mismatch. It sits directly in front of the SR flip-flop and is the only driver of its `s`/`r` pins.

---
 rtl/sr_ff_arbiter.sv | 123 ++++++++++++
 tb/tb_sr_ff_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_ff_arbiter.sv
// Round-robin arbiter sharing one SR flip-flop between two requesters.
// Each grant drives s or r for a fixed pulse, then checks q, then idles for a gap.
module sr_ff_arbiter #(
   parameter int PULSE_CYCLES = 2,
   parameter int GAP_CYCLES   = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic req_a,
   input  logic op_a,
   output logic ack_a,
   input  logic req_b,
   input  logic op_b,
   output logic ack_b,
   output logic s,
   output logic r,
   input  logic q_in,
   output logic busy,
   output logic err
);

   typedef enum logic [1:0] {IDLE, DRIVE, CHECK, GAP} state_t;

   localparam logic [7:0] PULSE_LOAD = 8'(PULSE_CYCLES - 1);
   localparam logic [7:0] GAP_LOAD   = 8'(GAP_CYCLES - 1);
   localparam bit         HAS_GAP    = (GAP_CYCLES != 0);

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       op_q, op_d;
   logic       win_b_q, win_b_d;
   logic       last_b_q, last_b_d;
   logic       s_q, s_d, r_q, r_d;
   logic       ack_a_q, ack_a_d, ack_b_q, ack_b_d;
   logic       busy_q, busy_d, err_q, err_d;
   logic       grant_a, grant_b;

   // On a tie the requester that was not granted last wins.
   assign grant_a = req_a & (~req_b | last_b_q);
   assign grant_b = req_b & ~grant_a;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      win_b_d  = win_b_q;
      last_b_d = last_b_q;
      err_d    = err_q;
      case (state_q)
         IDLE: begin
            if (grant_a | grant_b) begin
               win_b_d  = grant_b;
               op_d     = grant_b ? op_b : op_a;
               last_b_d = grant_b;
               cnt_d    = PULSE_LOAD;
               state_d  = DRIVE;
            end
         end
         DRIVE: begin
            if (cnt_q == 8'd0) state_d = CHECK;
            else               cnt_d   = cnt_q - 8'd1;
         end
         CHECK: begin
            if (q_in != op_q) err_d = 1'b1;
            if (HAS_GAP) begin
               cnt_d   = GAP_LOAD;
               state_d = GAP;
            end else begin
               state_d = IDLE;
            end
         end
         GAP: begin
            if (cnt_q == 8'd0) state_d = IDLE;
            else               cnt_d   = cnt_q - 8'd1;
         end
         default: state_d = IDLE;
      endcase

      // Outputs are decoded from the next state so they appear registered
      // in the same cycle the FSM enters the state.
      s_d     = (state_d == DRIVE) &  op_d;
      r_d     = (state_d == DRIVE) & ~op_d;
      ack_a_d = (state_d == CHECK) & ~win_b_d;
      ack_b_d = (state_d == CHECK) &  win_b_d;
      busy_d  = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= 8'd0;
         op_q     <= 1'b0;
         win_b_q  <= 1'b0;
         last_b_q <= 1'b1;
         s_q      <= 1'b0;
         r_q      <= 1'b0;
         ack_a_q  <= 1'b0;
         ack_b_q  <= 1'b0;
         busy_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         win_b_q  <= win_b_d;
         last_b_q <= last_b_d;
         s_q      <= s_d;
         r_q      <= r_d;
         ack_a_q  <= ack_a_d;
         ack_b_q  <= ack_b_d;
         busy_q   <= busy_d;
         err_q    <= err_d;
      end
   end

   assign s     = s_q;
   assign r     = r_q;
   assign ack_a = ack_a_q;
   assign ack_b = ack_b_q;
   assign busy  = busy_q;
   assign err   = err_q;

endmodule

// File: tb/tb_sr_ff_arbiter.sv
// Self-checking bench for sr_ff_arbiter driving a behavioural SR flip-flop.
// Directed scenarios plus a randomized run against a schedule-level model.
module tb_sr_ff_arbiter;

   localparam int P = 2;
   localparam int G = 1;
   localparam int T = P + G + 2;

   logic clk, rst;
   logic req_a, op_a, req_b, op_b;
   logic ack_a, ack_b, s, r, busy, err;
   logic q_ff, force_low, q_in;
   bit   sr_overlap;
   int   n_cmp, n_fail;

   sr_ff_arbiter #(.PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
      .clk(clk), .rst(rst),
      .req_a(req_a), .op_a(op_a), .ack_a(ack_a),
      .req_b(req_b), .op_b(op_b), .ack_b(ack_b),
      .s(s), .r(r), .q_in(q_in), .busy(busy), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural SR flip-flop; force_low models a stuck readback.
   initial q_ff = 1'b0;
   always @(posedge clk) begin
      if (s === 1'b1)      q_ff <= 1'b1;
      else if (r === 1'b1) q_ff <= 1'b0;
   end
   assign q_in = force_low ? 1'b0 : q_ff;

   initial sr_overlap = 1'b0;
   always @(negedge clk) if (s === 1'b1 && r === 1'b1) sr_overlap = 1'b1;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_pulse();
      rst = 1'b1; req_a = 1'b0; req_b = 1'b0; force_low = 1'b0;
      cyc();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; req_a = 1'b1; req_b = 1'b1; op_a = 1'b1; op_b = 1'b0; force_low = 1'b0;
      for (int i = 1; i <= 2; i++) begin
         cyc();
         n_cmp++;
         if ({s, r, ack_a, ack_b, busy, err} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset cycle %0d: s,r,ack_a,ack_b,busy,err=%b%b%b%b%b%b required 000000",
                     i, s, r, ack_a, ack_b, busy, err);
         end
      end
      rst = 1'b0; req_a = 1'b0; req_b = 1'b0;
      cyc();
      n_cmp++;
      if ({s, r, ack_a, ack_b, busy, err} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_release: s,r,ack_a,ack_b,busy,err=%b%b%b%b%b%b required 000000",
                  s, r, ack_a, ack_b, busy, err);
      end
      $display("test_reset done");
   endtask

   task automatic test_single();
      bit es, eaa, eb;
      req_a = 1'b1; op_a = 1'b1;
      for (int i = 1; i <= T; i++) begin
         cyc();
         es  = (i <= P);
         eaa = (i == P + 1);
         eb  = (i <= P + G + 1);
         n_cmp++;
         if ({s, r, ack_a, ack_b, busy, err} !== {es, 1'b0, eaa, 1'b0, eb, 1'b0}) begin
            n_fail++;
            $display("FAIL single cycle %0d: s,r,ack_a,ack_b,busy,err=%b%b%b%b%b%b required %b0%b0%b0",
                     i, s, r, ack_a, ack_b, busy, err, es, eaa, eb);
         end
         if (eaa) begin
            req_a = 1'b0;
            n_cmp++;
            if (q_ff !== 1'b1) begin
               n_fail++;
               $display("FAIL single_q: q=%b required 1", q_ff);
            end
         end
      end
      $display("test_single done");
   endtask

   task automatic test_tie();
      bit own_b, op, es, er, eaa, eab;
      int pos;
      reset_pulse();
      req_a = 1'b1; op_a = 1'b0; req_b = 1'b1; op_b = 1'b1;
      for (int i = 1; i <= 2 * T; i++) begin
         cyc();
         own_b = ((i - 1) / T) == 1;
         pos   = (i - 1) % T + 1;
         op    = own_b;
         es    = (pos <= P) && op;
         er    = (pos <= P) && !op;
         eaa   = (pos == P + 1) && !own_b;
         eab   = (pos == P + 1) && own_b;
         n_cmp++;
         if ({s, r, ack_a, ack_b} !== {es, er, eaa, eab}) begin
            n_fail++;
            $display("FAIL tie cycle %0d: s,r,ack_a,ack_b=%b%b%b%b required %b%b%b%b",
                     i, s, r, ack_a, ack_b, es, er, eaa, eab);
         end
         if (eaa) req_a = 1'b0;
         if (eab) req_b = 1'b0;
      end
      n_cmp++;
      if (q_ff !== 1'b1) begin
         n_fail++;
         $display("FAIL tie_final_q: q=%b required 1", q_ff);
      end
      n_cmp++;
      if (sr_overlap !== 1'b0) begin
         n_fail++;
         $display("FAIL tie_sr_overlap: overlap=%b required 0", sr_overlap);
      end
      $display("test_tie done");
   endtask

   task automatic test_round_robin();
      bit own_b, op, oa, ob, es, er, eaa, eab;
      int pos, prev_ack, na, nb;
      reset_pulse();
      oa = 1'($urandom_range(1)); ob = 1'($urandom_range(1));
      req_a = 1'b1; op_a = oa; req_b = 1'b1; op_b = ob;
      prev_ack = -1; na = 0; nb = 0;
      for (int i = 1; i <= 4 * T; i++) begin
         cyc();
         own_b = (((i - 1) / T) % 2) == 1;
         pos   = (i - 1) % T + 1;
         op    = own_b ? ob : oa;
         es    = (pos <= P) && op;
         er    = (pos <= P) && !op;
         eaa   = (pos == P + 1) && !own_b;
         eab   = (pos == P + 1) && own_b;
         n_cmp++;
         if ({s, r, ack_a, ack_b} !== {es, er, eaa, eab}) begin
            n_fail++;
            $display("FAIL rr cycle %0d: s,r,ack_a,ack_b=%b%b%b%b required %b%b%b%b",
                     i, s, r, ack_a, ack_b, es, er, eaa, eab);
         end
         if (ack_a === 1'b1 || ack_b === 1'b1) begin
            if (prev_ack >= 0) begin
               n_cmp++;
               if (i - prev_ack != T) begin
                  n_fail++;
                  $display("FAIL rr_spacing: ack gap=%0d required %0d", i - prev_ack, T);
               end
            end
            prev_ack = i;
         end
         if (eaa) begin na++; if (na == 2) req_a = 1'b0; end
         if (eab) begin nb++; if (nb == 2) req_b = 1'b0; end
      end
      $display("test_round_robin done");
   endtask

   task automatic test_mismatch();
      reset_pulse();
      force_low = 1'b1; req_a = 1'b1; op_a = 1'b1;
      for (int i = 1; i <= T; i++) begin
         cyc();
         if (i == P + 1) req_a = 1'b0;
         if (i == P + 2) force_low = 1'b0;
         if (i <= P) begin
            n_cmp++;
            if (err !== 1'b0) begin
               n_fail++;
               $display("FAIL mismatch_pre cycle %0d: err=%b required 0", i, err);
            end
         end else if (i >= P + 2) begin
            n_cmp++;
            if (err !== 1'b1) begin
               n_fail++;
               $display("FAIL mismatch_set cycle %0d: err=%b required 1", i, err);
            end
         end
      end
      req_a = 1'b1; op_a = 1'b1;
      for (int i = 1; i <= 2 * T; i++) begin
         cyc();
         if (i == T + P + 1) req_a = 1'b0;
         n_cmp++;
         if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL mismatch_sticky cycle %0d: err=%b required 1", i, err);
         end
      end
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      n_cmp++;
      if (err !== 1'b0) begin
         n_fail++;
         $display("FAIL mismatch_clear: err=%b required 0", err);
      end
      $display("test_mismatch done");
   endtask

   task automatic test_reset_mid_drive();
      bit own_b, op, oa, ob, es, er, eaa, eab;
      int pos;
      reset_pulse();
      req_a = 1'b1; op_a = 1'b1;
      cyc();
      n_cmp++;
      if (s !== 1'b1) begin
         n_fail++;
         $display("FAIL middrive_first: s=%b required 1", s);
      end
      rst = 1'b1;
      cyc();
      n_cmp++;
      if ({s, r, ack_a, ack_b, busy, err} !== 6'b0) begin
         n_fail++;
         $display("FAIL middrive_abort: s,r,ack_a,ack_b,busy,err=%b%b%b%b%b%b required 000000",
                  s, r, ack_a, ack_b, busy, err);
      end
      oa = 1'($urandom_range(1)); ob = 1'($urandom_range(1));
      rst = 1'b0; req_a = 1'b1; op_a = oa; req_b = 1'b1; op_b = ob;
      for (int i = 1; i <= 2 * T; i++) begin
         cyc();
         own_b = ((i - 1) / T) == 1;
         pos   = (i - 1) % T + 1;
         op    = own_b ? ob : oa;
         es    = (pos <= P) && op;
         er    = (pos <= P) && !op;
         eaa   = (pos == P + 1) && !own_b;
         eab   = (pos == P + 1) && own_b;
         n_cmp++;
         if ({s, r, ack_a, ack_b} !== {es, er, eaa, eab}) begin
            n_fail++;
            $display("FAIL middrive_tie cycle %0d: s,r,ack_a,ack_b=%b%b%b%b required %b%b%b%b",
                     i, s, r, ack_a, ack_b, es, er, eaa, eab);
         end
         if (eaa) req_a = 1'b0;
         if (eab) req_b = 1'b0;
      end
      $display("test_reset_mid_drive done");
   endtask

   // Model: a grant at cycle c owns cycles c+1 .. c+P+G+1; the block is
   // back in IDLE (sampling requests) from cycle c+P+G+2 on.
   task automatic test_random();
      bit active, own_b, cur_op, last_b;
      bit es, er, eaa, eab, eb;
      int start, d, n_ack;
      reset_pulse();
      active = 1'b0; last_b = 1'b1; start = 0; n_ack = 0;
      es = 0; er = 0; eaa = 0; eab = 0; eb = 0; own_b = 0; cur_op = 0;
      for (int t = 0; t < 400; t++) begin
         if (t > 0) begin
            cyc();
            d   = t - start;
            es  = active && d >= 1 && d <= P && cur_op;
            er  = active && d >= 1 && d <= P && !cur_op;
            eaa = active && d == P + 1 && !own_b;
            eab = active && d == P + 1 && own_b;
            eb  = active && d >= 1 && d <= P + G + 1;
            n_cmp++;
            if ({s, r, ack_a, ack_b, busy, err} !== {es, er, eaa, eab, eb, 1'b0}) begin
               n_fail++;
               $display("FAIL random t=%0d: s,r,ack_a,ack_b,busy,err=%b%b%b%b%b%b required %b%b%b%b%b0",
                        t, s, r, ack_a, ack_b, busy, err, es, er, eaa, eab, eb);
            end
            if (eaa || eab) n_ack++;
         end
         if (eaa) begin
            if ($urandom_range(1) == 1) req_a = 1'b0;
         end else if (!req_a && $urandom_range(2) == 0) begin
            req_a = 1'b1; op_a = 1'($urandom_range(1));
         end
         if (eab) begin
            if ($urandom_range(1) == 1) req_b = 1'b0;
         end else if (!req_b && $urandom_range(2) == 0) begin
            req_b = 1'b1; op_b = 1'($urandom_range(1));
         end
         if ((!active || t - start >= P + G + 2) && (req_a || req_b)) begin
            own_b  = req_b && (!req_a || !last_b);
            last_b = own_b;
            cur_op = own_b ? op_b : op_a;
            start  = t;
            active = 1'b1;
         end
      end
      n_cmp++;
      if (sr_overlap !== 1'b0) begin
         n_fail++;
         $display("FAIL random_sr_overlap: overlap=%b required 0", sr_overlap);
      end
      $display("test_random done: %0d commands acknowledged", n_ack);
   endtask

   initial begin
      n_cmp = 0; n_fail = 0;
      rst = 1'b1; req_a = 1'b0; req_b = 1'b0; op_a = 1'b0; op_b = 1'b0; force_low = 1'b0;
      #2;
      test_reset();
      test_single();
      test_tie();
      test_round_robin();
      test_mismatch();
      test_reset_mid_drive();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
